// File: rtl/proc_in_pkg.sv
// Shared constants and helpers for the processor input buffer.
package proc_in_pkg;
  localparam int NUBITS_DEF = 31;
  localparam int NUIOIN_DEF = 2;
  localparam int DEPTH_DEF  = 8;

  // Bits needed to index d values; never less than 1.
  function automatic int ptr_w(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction
endpackage

// File: rtl/proc_in_buf_if.sv
// Producer-side valid/ready stream, one lane per processor input port.
interface proc_in_buf_if #(
  parameter int NUBITS = 31,
  parameter int NUIOIN = 2
);
  logic [NUIOIN*NUBITS-1:0] s_data;
  logic [NUIOIN-1:0]        s_valid;
  logic [NUIOIN-1:0]        s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/proc_in_fifo.sv
// Single-channel circular FIFO; push/pop are ignored when full/empty.
module proc_in_fifo
  import proc_in_pkg::*;
#(
  parameter int W     = NUBITS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [W-1:0]                  din,
  output logic [W-1:0]                  head,
  output logic [ptr_w(DEPTH+1)-1:0]     count,
  output logic                          empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = ptr_w(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of 2, so natural pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset: nothing is readable while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/proc_in_buf.sv
// Per-port input FIFOs feeding the processor data input via a one-hot read strobe.
module proc_in_buf
  import proc_in_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NUIOIN = NUIOIN_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  proc_in_buf_if.slave             s,
  input  logic [NUIOIN-1:0]        req_in,
  output logic signed [NUBITS-1:0] io_in,
  output logic [NUIOIN-1:0]        empty,
  output logic [NUIOIN-1:0]        underflow,
  output logic                     req_err
);
  localparam int CW = ptr_w(DEPTH+1);

  logic [NUIOIN-1:0][NUBITS-1:0] heads;
  logic [NUIOIN-1:0][CW-1:0]     cnt;
  logic [NUIOIN-1:0]             fifo_empty, rdy, push, pop;
  logic                          multi, onehot;

  assign multi  = |(req_in & (req_in - NUIOIN'(1)));
  assign onehot = (|req_in) & ~multi;
  assign pop    = onehot ? req_in : '0;
  assign push   = s.s_valid & rdy;
  assign s.s_ready = rdy;
  assign empty  = rst ? '1 : fifo_empty;

  genvar k;
  for (k = 0; k < NUIOIN; k++) begin : g_ch
    // Ready comes from registered count only, never from req_in.
    assign rdy[k] = rst | (cnt[k] != CW'(DEPTH));

    proc_in_fifo #(.W(NUBITS), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (s.s_data[k*NUBITS +: NUBITS]),
      .head  (heads[k]),
      .count (cnt[k]),
      .empty (fifo_empty[k])
    );
  end

  always_comb begin
    io_in = '0;
    for (int i = 0; i < NUIOIN; i++)
      if (pop[i] && !fifo_empty[i] && !rst) io_in = $signed(heads[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= '0;
      req_err   <= 1'b0;
    end else begin
      underflow <= underflow | (pop & fifo_empty);
      req_err   <= req_err | multi;
    end
  end
endmodule

// File: tb/tb_proc_in_buf.sv
// Directed bench for proc_in_buf: ordering, full/empty edges, error flags, reset.
module tb_proc_in_buf;
  import proc_in_pkg::*;
  localparam int NB = 31;
  localparam int NP = 2;
  localparam int DP = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        req_in;
  logic signed [NB-1:0] io_in;
  logic [NP-1:0]        empty, underflow;
  logic                 req_err;
  int                   checks = 0;
  int                   errors = 0;
  int                   q0[$], q1[$];

  proc_in_buf_if #(.NUBITS(NB), .NUIOIN(NP)) bus ();

  proc_in_buf #(.NUBITS(NB), .NUIOIN(NP), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .s(bus), .req_in(req_in), .io_in(io_in),
    .empty(empty), .underflow(underflow), .req_err(req_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input int v);
    bus.s_data[k*NB +: NB] = NB'(v);
  endtask

  task automatic push1(input int k, input int v);
    set_word(k, v);
    bus.s_valid = NP'(1 << k);
    cyc();
    bus.s_valid = '0;
  endtask

  task automatic read1(input string tag, input int k, input int exp);
    req_in = NP'(1 << k);
    #1 chk(tag, io_in, exp);
    cyc();
    req_in = '0;
  endtask

  initial begin
    rst = 1'b1; req_in = '0; bus.s_valid = '0; bus.s_data = '0;
    cyc(); cyc();
    chk("rst_empty", empty, 2'b11);
    chk("rst_ready", bus.s_ready, 2'b11);
    chk("rst_io", io_in, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_err", req_err, 0);
    rst = 1'b0;
    cyc();

    // ordered readback with sign and max positive value
    push1(0, 5); push1(0, -3); push1(0, 1073741823);
    chk("t1_notempty", empty[0], 0);
    read1("t1_rd0", 0, 5);
    read1("t1_rd1", 0, -3);
    read1("t1_rd2", 0, 1073741823);
    chk("t1_empty", empty[0], 1);
    chk("t1_io_idle", io_in, 0);

    // fill port 1, pop while a 9th push is offered
    for (int i = 0; i < DP; i++) push1(1, 100 + i);
    chk("t2_full", bus.s_ready[1], 0);
    set_word(1, 200); bus.s_valid = 2'b10; req_in = 2'b10;
    #1 chk("t2_pop_full", io_in, 100);
    cyc();
    req_in = '0;
    chk("t2_ready_back", bus.s_ready[1], 1);
    cyc();
    bus.s_valid = '0;
    chk("t2_full_again", bus.s_ready[1], 0);
    for (int i = 1; i < DP; i++) read1("t2_drain", 1, 100 + i);
    read1("t2_ninth", 1, 200);
    chk("t2_empty", empty[1], 1);

    // underflow with concurrent push on the same port
    set_word(0, 7); bus.s_valid = 2'b01; req_in = 2'b01;
    #1 chk("t3_uf_io", io_in, 0);
    cyc();
    bus.s_valid = '0; req_in = '0;
    chk("t3_uf", underflow, 2'b01);
    chk("t3_cnt1", empty, 2'b10);
    push1(1, 55);
    chk("t3_uf_held", underflow, 2'b01);
    read1("t3_rd7", 0, 7);
    read1("t3_rd55", 1, 55);
    chk("t3_empty", empty, 2'b11);

    // multi-hot strobe
    set_word(0, 11); set_word(1, 22); bus.s_valid = 2'b11;
    cyc();
    bus.s_valid = '0; req_in = 2'b11;
    #1 chk("t4_io", io_in, 0);
    cyc();
    req_in = '0;
    chk("t4_err", req_err, 1);
    chk("t4_nopop", empty, 2'b00);
    read1("t4_rd0", 0, 11);
    read1("t4_rd1", 1, 22);
    chk("t4_err_held", req_err, 1);
    chk("t4_uf_held", underflow, 2'b01);

    // interleaved traffic with wrap, against queue model
    for (int i = 0; i < 40; i++) begin
      logic [NP-1:0] v, r;
      int exp_io;
      v = (i % 2 == 0) ? 2'b01 : 2'b10;
      r = (i % 4 == 1) ? 2'b01 : (i % 4 == 3) ? 2'b10 : 2'b00;
      set_word(0, 1000 + i); set_word(1, -(2000 + i));
      bus.s_valid = v; req_in = r;
      exp_io = 0;
      if (r[0] && q0.size() > 0) exp_io = q0[0];
      if (r[1] && q1.size() > 0) exp_io = q1[0];
      #1;
      chk("t5_io", io_in, exp_io);
      chk("t5_rdy", bus.s_ready, {q1.size() < DP, q0.size() < DP});
      if (r[0] && q0.size() > 0) void'(q0.pop_front());
      if (r[1] && q1.size() > 0) void'(q1.pop_front());
      if (v[0] && bus.s_ready[0]) q0.push_back(1000 + i);
      if (v[1] && bus.s_ready[1]) q1.push_back(-(2000 + i));
      cyc();
    end
    bus.s_valid = '0; req_in = '0;
    while (q0.size() > 0) read1("t5_drain0", 0, q0.pop_front());
    while (q1.size() > 0) read1("t5_drain1", 1, q1.pop_front());
    chk("t5_empty", empty, 2'b11);

    // reset with words buffered discards them
    push1(0, 31); push1(0, 32); push1(1, 41); push1(1, 42);
    chk("t6_loaded", empty, 2'b00);
    rst = 1'b1; set_word(0, 99); bus.s_valid = 2'b11; req_in = 2'b01;
    #1 chk("t6_rst_io", io_in, 0);
    chk("t6_rst_rdy", bus.s_ready, 2'b11);
    cyc();
    rst = 1'b0; bus.s_valid = '0; req_in = '0;
    chk("t6_empty", empty, 2'b11);
    chk("t6_uf", underflow, 0);
    chk("t6_err", req_err, 0);
    chk("t6_rdy", bus.s_ready, 2'b11);
    read1("t6_old_gone", 0, 0);
    chk("t6_uf_after", underflow, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/proc_in_buf.md
PROC_IN_BUF -- requirements
Module: proc_in_buf

Interface
REQ-001 The block SHALL have parameter NUBITS, default 31, meaning the processor data word width (signed).
REQ-002 The block SHALL have parameter NUIOIN, default 2, meaning the number of processor input ports.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning entries per port FIFO; it is a power of 2 and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port s_data, input, NUIOIN*NUBITS bits: producer words; port k uses bits [k*NUBITS +: NUBITS].
REQ-007 The block SHALL have port s_valid, input, NUIOIN bits: per-port producer valid.
REQ-008 The block SHALL have port s_ready, output, NUIOIN bits: per-port ready to accept.
REQ-009 The block SHALL have port req_in, input, NUIOIN bits: one-hot read strobe from the processor's input address decoder.
REQ-010 The block SHALL have port io_in, output, NUBITS bits signed: the word driven to the processor data input.
REQ-011 The block SHALL have port empty, output, NUIOIN bits: per-port FIFO empty.
REQ-012 The block SHALL have port underflow, output, NUIOIN bits: sticky per-port flag for a read of an empty FIFO.
REQ-013 The block SHALL have port req_err, output, 1 bit: sticky flag for a multi-hot req_in.

Function
REQ-014 Each port k SHALL own an independent circular FIFO of DEPTH words, with a write pointer, a read pointer and a count ranging 0..DEPTH.
REQ-015 s_ready[k] SHALL be 1 exactly when count[k] < DEPTH; it is derived from registered state only, with no combinational path from req_in.
REQ-016 A push on port k SHALL occur when s_valid[k] and s_ready[k] are both 1: the word is written at the write pointer, and the pointer increments modulo DEPTH.
REQ-017 When req_in is one-hot with bit k set and count[k] > 0, io_in SHALL equal the head word of FIFO k combinationally in that cycle, and the read pointer SHALL increment modulo DEPTH at the clock edge.
REQ-018 When req_in is zero, io_in SHALL be 0 and no FIFO pops.
REQ-019 When req_in has more than one bit set, io_in SHALL be 0, no FIFO pops, and req_err SHALL be set at the next edge.
REQ-020 When req_in[k] is asserted (one-hot) while count[k] = 0, io_in SHALL be 0, the pointers SHALL be unchanged, and underflow[k] SHALL be set at the next edge.
REQ-021 A simultaneous push and pop on the same non-empty, non-full port SHALL leave count unchanged and move both pointers.
REQ-022 A push and a pop on an empty port in the same cycle SHALL be treated as an underflow plus a successful push; there is no bypass, and count becomes 1.
REQ-023 A pop on a full port SHALL free one entry; s_ready rises in the following cycle, and a push offered in the same cycle is not accepted.
REQ-024 empty[k] SHALL be 1 exactly when count[k] = 0.
REQ-025 FIFO word data SHALL be stored and returned bit-exact, with the sign preserved and no width change.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL have no effect on data ordering; the FIFO is strictly first-in first-out.
REQ-027 underflow and req_err, once set, SHALL stay set until rst.

Reset
REQ-028 While rst = 1 at a clock edge, the block SHALL clear all pointers and counts, and clear underflow and req_err.
REQ-029 During and after reset, the block SHALL drive empty = all ones, s_ready = all ones and io_in = 0.
REQ-030 A reset mid-operation SHALL discard all buffered words; pushes and pops presented in a reset cycle SHALL be ignored.
REQ-031 Storage array contents SHALL NOT need reset, because they are unreadable while count = 0.

Structure
REQ-032 A shared package proc_in_pkg SHALL hold the default NUBITS, NUIOIN and DEPTH constants and a log2 pointer-width function.
REQ-033 The block SHALL use one sub-module, proc_in_fifo (a single-channel FIFO with push, pop, head, count and empty), instantiated NUIOIN times by generate.
REQ-034 The one-hot check, io_in multiplexer and sticky flags SHALL reside in proc_in_buf.

Verification
REQ-035 Verification SHALL cover: after reset, push 5, -3, 1073741823 on port 0, then three cycles of req_in=01 -> io_in reads 5, -3, 1073741823 in order and empty[0] returns to 1.
REQ-036 Verification SHALL cover: push 8 words on port 1 -> s_ready[1]=0; pop once via req_in=10 -> s_ready[1]=1 in the next cycle; a 9th push is accepted only after that.
REQ-037 Verification SHALL cover: req_in=01 on empty port 0 -> io_in=0 and underflow=01 held through later traffic; a concurrent push of 7 gives count 1 and a later read returns 7.
REQ-038 Verification SHALL cover: req_in=11 with both FIFOs holding data -> io_in=0, no pointer change and req_err=1.
REQ-039 Verification SHALL cover: 20 interleaved push/pop cycles per port with wrap past DEPTH -> output order matches a scoreboard model.
REQ-040 Verification SHALL cover: rst asserted with 4 words buffered -> next cycle empty=11, counts 0, flags cleared and old data never returned.
